// File: rtl/usb3_pkg.sv
// Shared definitions for the FX3 slave-FIFO read path: state codes and bus widths.
// ST_DATA is also decoded by the downstream RAM cache stage, so its value must not change.
package usb3_pkg;

    localparam int ST_W  = 4;
    localparam int BUS_W = 32;
    localparam int CNT_W = 11;

    typedef enum logic [ST_W-1:0] {
        ST_IDLE  = 4'd0,
        ST_SEL   = 4'd2,
        ST_OE    = 4'd3,
        ST_FILL  = 4'd4,
        ST_DATA  = 4'd6,
        ST_DRAIN = 4'd7,
        ST_GAP   = 4'd8
    } state_t;

endpackage

// File: rtl/usb3_burst_cnt.sv
// Loadable up-counter with a terminal-count flag; used for the issue, receive and gap counts.
module usb3_burst_cnt
    import usb3_pkg::*;
#(
    parameter int             W  = CNT_W,
    parameter logic [W-1:0]   TC = '0
) (
    input  logic         wrclock,
    input  logic         rst_n,
    input  logic         i_load,
    input  logic [W-1:0] i_load_val,
    input  logic         i_inc,
    output logic [W-1:0] o_cnt,
    output logic         o_tc
);

    logic [W-1:0] r_cnt;

    always_ff @(posedge wrclock or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= i_load_val;
        end else if (i_inc) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign o_cnt = r_cnt;
    assign o_tc  = (r_cnt == TC);

endmodule

// File: rtl/usb3_slfifo_rd.sv
// FX3 synchronous slave-FIFO burst read master feeding the RAM cache stage.
// Optional macro USB3_RD_XOR_EN adds the burst_xor checksum output.
module usb3_slfifo_rd
    import usb3_pkg::*;
#(
    parameter int         BURST_LEN  = 256,
    parameter int         RD_LATENCY = 2,
    parameter logic [1:0] FIFO_ADDR  = 2'b11,
    parameter int         GAP_CYCLES = 3
) (
    input  logic             wrclock,
    input  logic             rst_n,
    input  logic             enable,
    input  logic             usb3_flaga,
    input  logic [BUS_W-1:0] usb3_dq,
    output logic             slcs_n,
    output logic             sloe_n,
    output logic             slrd_n,
    output logic [1:0]       fifoaddr,
    output logic [BUS_W-1:0] data,
`ifdef USB3_RD_XOR_EN
    output logic [BUS_W-1:0] burst_xor,
`endif
    output logic [ST_W-1:0]  usb_rd_state,
    output logic             burst_done,
    output logic [15:0]      burst_cnt
);

    localparam logic [CNT_W-1:0] L_ISSUE_TC  = CNT_W'(BURST_LEN);
    localparam logic [CNT_W-1:0] L_FILL_LAST = CNT_W'(RD_LATENCY);
    localparam logic [CNT_W-1:0] L_RCV_TC    = CNT_W'(BURST_LEN - 1);
    localparam logic [CNT_W-1:0] L_GAP_TC    = CNT_W'(GAP_CYCLES - 1);

    state_t             r_state;
    state_t             w_next_state;
    logic [BUS_W-1:0]   r_data;
    logic [15:0]        r_burst_cnt;
    logic [CNT_W-1:0]   w_issue_cnt;
    logic [CNT_W-1:0]   w_rcv_cnt;
    logic [CNT_W-1:0]   w_gap_cnt;
    logic               w_issue_tc;
    logic               w_rcv_tc;
    logic               w_gap_tc;
    logic               w_fill_last;
    logic               w_cap;

    // Downstream contract: data is a valid word on every cycle usb_rd_state==ST_DATA;
    // there is no backpressure, so a burst only starts once the FX3 holds a full block.
    assign w_fill_last = (r_state == ST_FILL) && (w_issue_cnt == L_FILL_LAST);
    assign w_cap       = w_fill_last || ((r_state == ST_DATA) && (w_rcv_cnt != L_RCV_TC));

    usb3_burst_cnt #(.W(CNT_W), .TC(L_ISSUE_TC)) u_issue_cnt (
        .wrclock    (wrclock),
        .rst_n      (rst_n),
        .i_load     (r_state == ST_IDLE),
        .i_load_val ('0),
        .i_inc      (!slrd_n),
        .o_cnt      (w_issue_cnt),
        .o_tc       (w_issue_tc)
    );

    usb3_burst_cnt #(.W(CNT_W), .TC(L_RCV_TC)) u_rcv_cnt (
        .wrclock    (wrclock),
        .rst_n      (rst_n),
        .i_load     (r_state == ST_IDLE),
        .i_load_val ('0),
        .i_inc      (r_state == ST_DATA),
        .o_cnt      (w_rcv_cnt),
        .o_tc       (w_rcv_tc)
    );

    usb3_burst_cnt #(.W(CNT_W), .TC(L_GAP_TC)) u_gap_cnt (
        .wrclock    (wrclock),
        .rst_n      (rst_n),
        .i_load     (r_state != ST_GAP),
        .i_load_val ('0),
        .i_inc      (r_state == ST_GAP),
        .o_cnt      (w_gap_cnt),
        .o_tc       (w_gap_tc)
    );

    always_ff @(posedge wrclock or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = ST_IDLE;
        case (r_state)
            ST_IDLE:  w_next_state = (enable && usb3_flaga) ? ST_SEL : ST_IDLE;
            ST_SEL:   w_next_state = ST_OE;
            ST_OE:    w_next_state = ST_FILL;
            ST_FILL:  w_next_state = w_fill_last ? ST_DATA : ST_FILL;
            ST_DATA:  w_next_state = w_rcv_tc ? ST_DRAIN : ST_DATA;
            ST_DRAIN: w_next_state = ST_GAP;
            ST_GAP:   w_next_state = w_gap_tc ? ST_IDLE : ST_GAP;
            default:  w_next_state = ST_IDLE;
        endcase
    end

    // Strobes decode straight from the state register so an async reset releases them at once.
    always_comb begin
        slcs_n     = 1'b1;
        sloe_n     = 1'b1;
        slrd_n     = 1'b1;
        fifoaddr   = 2'b00;
        burst_done = 1'b0;
        case (r_state)
            ST_SEL: begin
                slcs_n   = 1'b0;
                fifoaddr = FIFO_ADDR;
            end
            ST_OE: begin
                slcs_n   = 1'b0;
                sloe_n   = 1'b0;
                fifoaddr = FIFO_ADDR;
            end
            ST_FILL, ST_DATA: begin
                slcs_n   = 1'b0;
                sloe_n   = 1'b0;
                slrd_n   = w_issue_tc;
                fifoaddr = FIFO_ADDR;
            end
            ST_DRAIN: begin
                slcs_n   = 1'b0;
                fifoaddr = FIFO_ADDR;
            end
            ST_GAP: begin
                burst_done = (w_gap_cnt == '0);
            end
            default: begin
                slcs_n = 1'b1;
            end
        endcase
    end

    always_ff @(posedge wrclock or negedge rst_n) begin
        if (!rst_n) begin
            r_data      <= '0;
            r_burst_cnt <= '0;
        end else begin
            if (w_cap) begin
                r_data <= usb3_dq;
            end
            if (r_state == ST_DRAIN) begin
                r_burst_cnt <= r_burst_cnt + 16'd1;
            end
        end
    end

`ifdef USB3_RD_XOR_EN
    logic [BUS_W-1:0] r_xor_acc;
    logic [BUS_W-1:0] r_burst_xor;

    always_ff @(posedge wrclock or negedge rst_n) begin
        if (!rst_n) begin
            r_xor_acc   <= '0;
            r_burst_xor <= '0;
        end else begin
            if (r_state == ST_IDLE) begin
                r_xor_acc <= '0;
            end else if (w_cap) begin
                r_xor_acc <= r_xor_acc ^ usb3_dq;
            end
            if (r_state == ST_DRAIN) begin
                r_burst_xor <= r_xor_acc;
            end
        end
    end

    assign burst_xor = r_burst_xor;
`endif

    assign data         = r_data;
    assign burst_cnt    = r_burst_cnt;
    assign usb_rd_state = r_state;

endmodule
